ldst_cmd_queue: RTL and testbench

LDST_CMD_QUEUE -- requirements
Module: ldst_cmd_queue

---
 rtl/ldst_cmd_queue_if.sv | 40 ++++
 rtl/ldst_cmd_queue.sv | 157 +++++++++++++++
 tb/tb_ldst_cmd_queue.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/ldst_cmd_queue_if.sv
// rtl/ldst_cmd_queue_if.sv - command, issue and status signals of ldst_cmd_queue
interface ldst_cmd_queue_if #(
    parameter int RF_ADDR_W  = 10,
    parameter int LINE_NUM_W = 11,
    parameter int DEPTH      = 4
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic                   cmd_valid;
    logic                   cmd_ready;
    logic                   cmd_is_store;
    logic [31:0]            cmd_sdram_addr;
    logic [RF_ADDR_W-1:0]   cmd_rf_addr;
    logic [LINE_NUM_W-1:0]  cmd_line_num;
    logic                   flush;
    logic                   load_start;
    logic                   store_start;
    logic [31:0]            ldst_sdram_addr;
    logic [RF_ADDR_W-1:0]   ldst_rf_addr;
    logic [LINE_NUM_W-1:0]  ldst_line_num;
    logic                   eng_done;
    logic                   busy;
    logic [CNT_W-1:0]       q_count;
    logic [15:0]            cmpl_cnt;
    logic                   err_zero_len;

    modport slave (
        input  cmd_valid, cmd_is_store, cmd_sdram_addr, cmd_rf_addr, cmd_line_num,
               flush, eng_done,
        output cmd_ready, load_start, store_start, ldst_sdram_addr, ldst_rf_addr,
               ldst_line_num, busy, q_count, cmpl_cnt, err_zero_len
    );

    modport master (
        output cmd_valid, cmd_is_store, cmd_sdram_addr, cmd_rf_addr, cmd_line_num,
               flush, eng_done,
        input  cmd_ready, load_start, store_start, ldst_sdram_addr, ldst_rf_addr,
               ldst_line_num, busy, q_count, cmpl_cnt, err_zero_len
    );
endinterface

// File: rtl/ldst_cmd_queue.sv
// rtl/ldst_cmd_queue.sv - in-order load/store command FIFO with one-at-a-time engine issue
// Optional: LDST_CMDQ_ZERO_DROP_EN drops zero-length commands and flags err_zero_len.
module ldst_cmd_queue #(
    parameter int RF_ADDR_W  = 10,
    parameter int LINE_NUM_W = 11,
    parameter int DEPTH      = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    ldst_cmd_queue_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_ISSUE     = 2'd1;
    localparam logic [1:0] S_WAIT_BUSY = 2'd2;
    localparam logic [1:0] S_WAIT_DONE = 2'd3;

    logic [1:0]             r_state;
    logic [CNT_W-1:0]       r_count;
    logic [PTR_W-1:0]       r_wr_ptr;
    logic [PTR_W-1:0]       r_rd_ptr;

    logic                   r_fifo_store [DEPTH];
    logic [31:0]            r_fifo_addr  [DEPTH];
    logic [RF_ADDR_W-1:0]   r_fifo_rf    [DEPTH];
    logic [LINE_NUM_W-1:0]  r_fifo_lines [DEPTH];

    logic                   r_load_start;
    logic                   r_store_start;
    logic [31:0]            r_sdram_addr;
    logic [RF_ADDR_W-1:0]   r_rf_addr;
    logic [LINE_NUM_W-1:0]  r_line_num;
    logic [15:0]            r_cmpl_cnt;

    logic                   w_cmd_ready;
    logic                   w_accept;
    logic                   w_zero_drop;
    logic                   w_push;
    logic                   w_pop;

    // Ready looks only at the registered count, so a pop in the same cycle never opens a full queue.
    assign w_cmd_ready = (r_count < CNT_W'(DEPTH)) && !bus.flush;
    assign w_accept    = bus.cmd_valid && w_cmd_ready;

`ifdef LDST_CMDQ_ZERO_DROP_EN
    logic r_err_zero_len;

    assign w_zero_drop = w_accept && (bus.cmd_line_num == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_zero_len <= 1'b0;
        end else if (w_zero_drop) begin
            r_err_zero_len <= 1'b1;
        end
    end

    assign bus.err_zero_len = r_err_zero_len;
`else
    assign w_zero_drop      = 1'b0;
    assign bus.err_zero_len = 1'b0;
`endif

    assign w_push = w_accept && !w_zero_drop;
    // Flush outranks the IDLE pop so a discarded head is never issued.
    assign w_pop  = (r_state == S_IDLE) && (r_count != '0) && bus.eng_done && !bus.flush;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_store[r_wr_ptr] <= bus.cmd_is_store;
            r_fifo_addr[r_wr_ptr]  <= bus.cmd_sdram_addr;
            r_fifo_rf[r_wr_ptr]    <= bus.cmd_rf_addr;
            r_fifo_lines[r_wr_ptr] <= bus.cmd_line_num;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (bus.flush) begin
            r_count  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // The start pulse is registered on the pop edge so it lines up with the ISSUE state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_load_start  <= 1'b0;
            r_store_start <= 1'b0;
            r_sdram_addr  <= '0;
            r_rf_addr     <= '0;
            r_line_num    <= '0;
            r_cmpl_cnt    <= '0;
        end else begin
            r_load_start  <= 1'b0;
            r_store_start <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_sdram_addr  <= r_fifo_addr[r_rd_ptr];
                        r_rf_addr     <= r_fifo_rf[r_rd_ptr];
                        r_line_num    <= r_fifo_lines[r_rd_ptr];
                        r_load_start  <= !r_fifo_store[r_rd_ptr];
                        r_store_start <= r_fifo_store[r_rd_ptr];
                        r_state       <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_state <= S_WAIT_BUSY;
                end
                S_WAIT_BUSY: begin
                    if (!bus.eng_done) begin
                        r_state <= S_WAIT_DONE;
                    end
                end
                S_WAIT_DONE: begin
                    if (bus.eng_done) begin
                        r_cmpl_cnt <= r_cmpl_cnt + 16'd1;
                        r_state    <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.cmd_ready       = w_cmd_ready;
    assign bus.load_start      = r_load_start;
    assign bus.store_start     = r_store_start;
    assign bus.ldst_sdram_addr = r_sdram_addr;
    assign bus.ldst_rf_addr    = r_rf_addr;
    assign bus.ldst_line_num   = r_line_num;
    assign bus.busy            = (r_state != S_IDLE) || (r_count != '0);
    assign bus.q_count         = r_count;
    assign bus.cmpl_cnt        = r_cmpl_cnt;
endmodule

// File: tb/tb_ldst_cmd_queue.sv
// tb/tb_ldst_cmd_queue.sv - randomized bench for ldst_cmd_queue against a queue-based reference model
module tb_ldst_cmd_queue;
    localparam int RF_ADDR_W  = 10;
    localparam int LINE_NUM_W = 11;
    localparam int DEPTH      = 4;

    localparam int P_IDLE      = 0;
    localparam int P_ISSUE     = 1;
    localparam int P_WAIT_BUSY = 2;
    localparam int P_WAIT_DONE = 3;

    typedef struct {
        logic                  st;
        logic [31:0]           addr;
        logic [RF_ADDR_W-1:0]  rf;
        logic [LINE_NUM_W-1:0] lines;
    } cmd_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ldst_cmd_queue_if #(.RF_ADDR_W(RF_ADDR_W), .LINE_NUM_W(LINE_NUM_W), .DEPTH(DEPTH)) bus ();

    ldst_cmd_queue #(.RF_ADDR_W(RF_ADDR_W), .LINE_NUM_W(LINE_NUM_W), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int   n_vec = 0;
    int   n_miscmp = 0;
    cmd_t mq[$];
    cmd_t m_cur;
    cmd_t idle_c;
    int   m_phase;
    int   m_cmpl;
    bit   m_err;
    int   eng_busy_cnt;
    int   eng_lat;
    bit   eng_hold;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miscmp++;
            $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", tag, $time, obs, exp);
        end
    endtask

    function automatic cmd_t mk(input bit st, input logic [31:0] addr, input int rf, input int lines);
        cmd_t c;
        c.st    = st;
        c.addr  = addr;
        c.rf    = RF_ADDR_W'(rf);
        c.lines = LINE_NUM_W'(lines);
        return c;
    endfunction

    function automatic cmd_t rnd_cmd();
        int lines;
        lines = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 2047));
        return mk($urandom_range(0, 1) == 1, $urandom, int'($urandom_range(0, 1023)), lines);
    endfunction

    task automatic model_reset();
        mq.delete();
        m_cur        = idle_c;
        m_phase      = P_IDLE;
        m_cmpl       = 0;
        m_err        = 1'b0;
        eng_busy_cnt = 0;
    endtask

    task automatic check_all();
        chk("q_count", 32'(bus.q_count), mq.size());
        chk("cmd_ready", 32'(bus.cmd_ready), 32'((mq.size() < DEPTH) && !bus.flush));
        chk("busy", 32'(bus.busy), 32'((m_phase != P_IDLE) || (mq.size() != 0)));
        chk("load_start", 32'(bus.load_start), 32'((m_phase == P_ISSUE) && !m_cur.st));
        chk("store_start", 32'(bus.store_start), 32'((m_phase == P_ISSUE) && m_cur.st));
        chk("ldst_sdram_addr", bus.ldst_sdram_addr, m_cur.addr);
        chk("ldst_rf_addr", 32'(bus.ldst_rf_addr), 32'(m_cur.rf));
        chk("ldst_line_num", 32'(bus.ldst_line_num), 32'(m_cur.lines));
        chk("cmpl_cnt", 32'(bus.cmpl_cnt), m_cmpl & 32'hFFFF);
        chk("err_zero_len", 32'(bus.err_zero_len), 32'(m_err));
    endtask

    // Called at a falling edge: drive one cycle, check, advance the model across the rising edge.
    task automatic step(input bit v, input cmd_t c, input bit fl);
        bit acc;
        bit pop;
        bit issuing;
        bus.cmd_valid      = v;
        bus.cmd_is_store   = c.st;
        bus.cmd_sdram_addr = c.addr;
        bus.cmd_rf_addr    = c.rf;
        bus.cmd_line_num   = c.lines;
        bus.flush          = fl;
        if (eng_busy_cnt > 0) begin
            bus.eng_done = 1'b0;
            eng_busy_cnt--;
        end else begin
            bus.eng_done = !eng_hold;
        end
        #1;
        check_all();
        acc     = v && (mq.size() < DEPTH) && !fl;
        pop     = (m_phase == P_IDLE) && (mq.size() != 0) && bus.eng_done && !fl;
        issuing = (m_phase == P_ISSUE);
        case (m_phase)
            P_IDLE:      if (pop) begin m_cur = mq.pop_front(); m_phase = P_ISSUE; end
            P_ISSUE:     m_phase = P_WAIT_BUSY;
            P_WAIT_BUSY: if (!bus.eng_done) m_phase = P_WAIT_DONE;
            default:     if (bus.eng_done) begin m_cmpl++; m_phase = P_IDLE; end
        endcase
        if (fl) begin
            mq.delete();
        end else if (acc) begin
`ifdef LDST_CMDQ_ZERO_DROP_EN
            if (c.lines == '0) m_err = 1'b1;
            else mq.push_back(c);
`else
            mq.push_back(c);
`endif
        end
        if (issuing) begin
            eng_busy_cnt = (eng_lat != 0) ? eng_lat : int'($urandom_range(1, 8));
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, idle_c, 1'b0);
    endtask

    // Reset is applied between edges so its asynchronous action is visible before any clock.
    task automatic do_reset();
        bus.cmd_valid = 1'b0;
        bus.flush     = 1'b0;
        bus.eng_done  = 1'b1;
        rst_n         = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        idle_c             = mk(1'b0, 32'h0, 0, 0);
        bus.cmd_valid      = 1'b0;
        bus.cmd_is_store   = 1'b0;
        bus.cmd_sdram_addr = '0;
        bus.cmd_rf_addr    = '0;
        bus.cmd_line_num   = '0;
        bus.flush          = 1'b0;
        bus.eng_done       = 1'b1;
        eng_hold           = 1'b0;
        eng_lat            = 0;
        model_reset();
        @(negedge clk);
        do_reset();

        // single load on an idle engine: pulse two cycles after the handshake
        step(1'b1, mk(1'b0, 32'h1000, 5, 3), 1'b0);
        idle(14);

        // fill the queue while the engine is busy; the fifth push must be refused
        eng_hold = 1'b1;
        for (int i = 0; i < 5; i++) step(1'b1, rnd_cmd(), 1'b0);
        idle(3);
        eng_hold = 1'b0;
        idle(60);

        // store, load, store with a 10-cycle engine
        eng_lat  = 10;
        eng_hold = 1'b1;
        step(1'b1, mk(1'b1, 32'hA000_0000, 1, 7), 1'b0);
        step(1'b1, mk(1'b0, 32'hA000_0100, 2, 8), 1'b0);
        step(1'b1, mk(1'b1, 32'hA000_0200, 3, 9), 1'b0);
        eng_hold = 1'b0;
        idle(50);

        // flush with one in flight and three queued
        for (int i = 0; i < 4; i++) step(1'b1, rnd_cmd(), 1'b0);
        step(1'b0, idle_c, 1'b1);
        idle(20);

        // zero-length command
        step(1'b1, mk(1'b0, 32'h0000_2000, 9, 0), 1'b0);
        idle(20);

        // reset while waiting on the engine with two queued
        for (int i = 0; i < 3; i++) step(1'b1, rnd_cmd(), 1'b0);
        for (int i = 0; i < 30 && m_phase != P_WAIT_DONE; i++) idle(1);
        chk("reached_wait_done", 32'(m_phase == P_WAIT_DONE), 32'd1);
        do_reset();
        idle(15);
        eng_lat = 0;

        // randomized traffic
        for (int seg = 0; seg < 16; seg++) begin
            int vprob;
            vprob    = (seg % 3 == 0) ? 20 : ((seg % 3 == 1) ? 50 : 90);
            eng_hold = ($urandom_range(0, 4) == 0);
            for (int i = 0; i < 100; i++) begin
                if ($urandom_range(0, 399) == 0) begin
                    do_reset();
                end else begin
                    step($urandom_range(0, 99) < vprob, rnd_cmd(), $urandom_range(0, 49) == 0);
                end
            end
        end
        eng_hold = 1'b0;
        idle(80);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end
endmodule
